// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and address typedef for the register file.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_NUM_RD   = 2;

  // Address width for a register file of n entries (never narrower than one bit).
  function automatic int calc_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A write or issue only touches state when it names an existing register
  // other than a hard-wired r0.
  function automatic logic reg_addr_ok(input int addr, input int nregs, input int zero_reg);
    return (addr < nregs) && !((zero_reg != 0) && (addr == 0));
  endfunction

  typedef logic [calc_aw(DEF_NUM_REGS)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one busy bit per register, set at issue and
// cleared at writeback, plus the WAW check that gates new reservations.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  ZERO_REG = 1,
  localparam int AW       = calc_aw(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic                iss_ready,
  output logic [NUM_REGS-1:0] busy_vec
);

  // Busy bits padded to the full address span so out-of-range lookups read 0.
  localparam int SPAN = 1 << AW;

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [SPAN-1:0]     busy_span;
  logic                wr_ok;
  logic                iss_ok;

  assign busy_span = SPAN'(busy);
  assign wr_ok     = wr_en && reg_addr_ok(int'(wr_addr), NUM_REGS, ZERO_REG);

  // A writeback landing on the requested register this cycle resolves the WAW hazard.
  assign iss_ready = !busy_span[iss_addr] || (wr_en && (wr_addr == iss_addr));
  assign iss_ok    = iss_en && iss_ready && reg_addr_ok(int'(iss_addr), NUM_REGS, ZERO_REG);
  assign busy_vec  = busy;

  // Next busy state: writeback clears first, then a same-cycle issue sets (set wins).
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (wr_ok && (wr_addr == AW'(r)))
        busy_nxt[r] = 1'b0;
      if (iss_ok && (iss_addr == AW'(r)))
        busy_nxt[r] = 1'b1;
    end
  end

  // Busy register; reset drops every outstanding reservation.
  always_ff @(posedge clock) begin
    if (!reset)
      busy <= '0;
    else
      busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with write-to-read bypass and an
// attached write-pending scoreboard for hazard detection in the control FSM.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_REGS = DEF_NUM_REGS,
  parameter int  NUM_RD   = DEF_NUM_RD,
  parameter int  ZERO_REG = 1,
  parameter int  BYPASS   = 1,
  localparam int AW       = calc_aw(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_addr,
  output logic                     iss_ready,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] rf [NUM_REGS];
  logic              wr_ok;

  assign wr_ok = wr_en && reg_addr_ok(int'(wr_addr), NUM_REGS, ZERO_REG);

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clock     (clock),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .busy_vec  (busy_vec)
  );

  // Register array: cleared on reset, otherwise one valid write per cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        rf[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (wr_ok && (wr_addr == AW'(r)))
          rf[r] <= wr_data;
    end
  end

  // Read muxing per port: r0 and unmapped addresses read 0; a same-cycle
  // write to the addressed register is forwarded and hides its busy bit.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [AW-1:0] sel;
      sel = rd_addr[i*AW +: AW];
      for (int r = 0; r < NUM_REGS; r++) begin
        if ((sel == AW'(r)) && !((ZERO_REG != 0) && (r == 0))) begin
          rd_data[i*DATA_W +: DATA_W] = rf[r];
          rd_busy[i]                  = busy_vec[r];
        end
      end
      if ((BYPASS != 0) && wr_en && (wr_addr == sel)) begin
        rd_busy[i] = 1'b0;
        if (wr_ok)
          rd_data[i*DATA_W +: DATA_W] = wr_data;
      end
    end
  end

endmodule
